// File: rtl/alu_acc_ctrl.sv
// Accumulator controller wrapped around an external 8-bit ALU: registers the ALU
// inputs, holds them for SETTLE cycles, captures sum/carry and hands the result out.
module alu_acc_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_load,
    input  logic             cmd_use_carry,
    output logic [2:0]       alu_oper,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_c_in,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_c_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic [CNT_W-1:0] op_count
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // EXEC  | ALU inputs held while settle_cnt counts down to zero
    // RESP  | result presented, waiting for res_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] settle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            acc        <= '0;
            carry      <= 1'b0;
            alu_oper   <= '0;
            alu_b      <= '0;
            alu_c_in   <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_load) begin
                            acc   <= cmd_data;
                            carry <= 1'b0;
                            state <= RESP;
                        end else begin
                            alu_oper   <= cmd_op;
                            alu_b      <= cmd_data;
                            alu_c_in   <= cmd_use_carry & carry;
                            settle_cnt <= SETTLE_LOAD;
                            state      <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (settle_cnt == 4'd0) begin
                        acc   <= alu_sum;
                        carry <= alu_c_out;
                        state <= RESP;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        op_count <= op_count + 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags come straight from the state register, no input paths.
    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == RESP);
    assign alu_a     = acc;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Bench for alu_acc_ctrl: two instances (SETTLE=1/CNT_W=4 and SETTLE=3/CNT_W=16),
// each driving a behavioural ALU, checked against a transaction-level model.
module tb_alu_acc_ctrl;

    localparam int SET [2] = '{1, 3};

    logic clk;
    logic       rst_n [2];
    logic       cmd_valid [2];
    logic       cmd_ready [2];
    logic [2:0] cmd_op [2];
    logic [7:0] cmd_data [2];
    logic       cmd_load [2];
    logic       cmd_use_carry [2];
    logic [2:0] alu_oper [2];
    logic [7:0] alu_a [2];
    logic [7:0] alu_b [2];
    logic       alu_c_in [2];
    logic [7:0] alu_sum [2];
    logic       alu_c_out [2];
    logic       res_valid [2];
    logic       res_ready [2];
    logic [7:0] acc [2];
    logic       carry [2];
    logic [3:0]  cnt0;
    logic [15:0] cnt1;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_acc [2];
    logic       m_carry [2];
    int         m_cnt [2];

    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic c);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b} + 9'(c);
            3'd1:    return {1'b0, a} + {1'b0, ~b} + 9'(c);
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            default: return {c, ~a};
        endcase
    endfunction

    function automatic logic [15:0] get_cnt(input int d);
        return (d == 0) ? {12'b0, cnt0} : cnt1;
    endfunction

    function automatic logic [15:0] exp_cnt(input int d);
        return (d == 0) ? 16'(m_cnt[d] % 16) : 16'(m_cnt[d] % 65536);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_alu
        assign {alu_c_out[g], alu_sum[g]} = alu_f(alu_oper[g], alu_a[g], alu_b[g], alu_c_in[g]);
    end

    alu_acc_ctrl #(.WIDTH(8), .SETTLE(1), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op[0]), .cmd_data(cmd_data[0]), .cmd_load(cmd_load[0]),
        .cmd_use_carry(cmd_use_carry[0]), .alu_oper(alu_oper[0]), .alu_a(alu_a[0]),
        .alu_b(alu_b[0]), .alu_c_in(alu_c_in[0]), .alu_sum(alu_sum[0]),
        .alu_c_out(alu_c_out[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
        .acc(acc[0]), .carry(carry[0]), .op_count(cnt0)
    );

    alu_acc_ctrl #(.WIDTH(8), .SETTLE(3), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op[1]), .cmd_data(cmd_data[1]), .cmd_load(cmd_load[1]),
        .cmd_use_carry(cmd_use_carry[1]), .alu_oper(alu_oper[1]), .alu_a(alu_a[1]),
        .alu_b(alu_b[1]), .alu_c_in(alu_c_in[1]), .alu_sum(alu_sum[1]),
        .alu_c_out(alu_c_out[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
        .acc(acc[1]), .carry(carry[1]), .op_count(cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset(input int d);
        m_acc[d] = 8'h00;
        m_carry[d] = 1'b0;
        m_cnt[d] = 0;
    endtask

    task automatic do_reset(input int d);
        @(posedge clk); #1;
        rst_n[d] = 1'b0;
        model_reset(d);
        #3;
        rst_n[d] = 1'b1;
    endtask

    // One full command: accept, hold/latency checks, result, handshake, count.
    task automatic run_cmd(input int d, input bit load, input logic [2:0] op,
                           input logic [7:0] data, input bit uc, input int hold,
                           input bit rr_high);
        logic [8:0] r;
        logic [7:0] a0;
        logic       cin;
        int         lat;
        int         exp_lat;
        a0 = m_acc[d];
        cin = uc & m_carry[d];
        r = load ? {1'b0, data} : alu_f(op, a0, data, cin);
        exp_lat = load ? 0 : SET[d];
        tests++;
        if (cmd_ready[d] !== 1'b1) begin
            fails++; $display("FAIL idle_ready d%0d: got %b want 1", d, cmd_ready[d]);
        end
        cmd_valid[d] = 1'b1; cmd_load[d] = load; cmd_op[d] = op;
        cmd_data[d] = data; cmd_use_carry[d] = uc; res_ready[d] = rr_high;
        @(posedge clk); #1;
        cmd_valid[d] = 1'b0;
        cmd_data[d] = 8'($urandom);
        cmd_op[d] = 3'($urandom);
        lat = 0;
        while (res_valid[d] !== 1'b1 && lat < 20) begin
            tests++;
            if (alu_b[d] !== data || alu_oper[d] !== op || alu_c_in[d] !== cin ||
                alu_a[d] !== a0 || cmd_ready[d] !== 1'b0) begin
                fails++;
                $display("FAIL exec_hold d%0d: b=%h op=%0d cin=%b a=%h rdy=%b want b=%h op=%0d cin=%b a=%h rdy=0",
                         d, alu_b[d], alu_oper[d], alu_c_in[d], alu_a[d], cmd_ready[d], data, op, cin, a0);
            end
            cmd_data[d] = 8'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (lat != exp_lat) begin
            fails++; $display("FAIL latency d%0d: got %0d want %0d", d, lat, exp_lat);
        end
        m_acc[d] = r[7:0];
        m_carry[d] = r[8];
        tests++;
        if (acc[d] !== m_acc[d] || carry[d] !== m_carry[d] || cmd_ready[d] !== 1'b0) begin
            fails++;
            $display("FAIL result d%0d: acc=%h carry=%b rdy=%b want acc=%h carry=%b rdy=0",
                     d, acc[d], carry[d], cmd_ready[d], m_acc[d], m_carry[d]);
        end
        if (!rr_high) begin
            repeat (hold) begin
                @(posedge clk); #1;
                tests++;
                if (res_valid[d] !== 1'b1 || acc[d] !== m_acc[d] || get_cnt(d) !== exp_cnt(d)) begin
                    fails++;
                    $display("FAIL resp_hold d%0d: valid=%b acc=%h cnt=%0d want 1 %h %0d",
                             d, res_valid[d], acc[d], get_cnt(d), m_acc[d], exp_cnt(d));
                end
            end
            res_ready[d] = 1'b1;
        end
        @(posedge clk); #1;
        res_ready[d] = 1'b0;
        m_cnt[d]++;
        tests++;
        if (res_valid[d] !== 1'b0 || cmd_ready[d] !== 1'b1 || get_cnt(d) !== exp_cnt(d)) begin
            fails++;
            $display("FAIL complete d%0d: valid=%b rdy=%b cnt=%0d want 0 1 %0d",
                     d, res_valid[d], cmd_ready[d], get_cnt(d), exp_cnt(d));
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (cmd_ready[d] !== 1'b1 || res_valid[d] !== 1'b0 || acc[d] !== 8'h00 ||
                carry[d] !== 1'b0 || get_cnt(d) !== 16'd0 || alu_b[d] !== 8'h00 ||
                alu_oper[d] !== 3'd0 || alu_c_in[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset_state d%0d: rdy=%b vld=%b acc=%h c=%b cnt=%0d b=%h op=%0d cin=%b",
                         d, cmd_ready[d], res_valid[d], acc[d], carry[d], get_cnt(d),
                         alu_b[d], alu_oper[d], alu_c_in[d]);
            end
        end
    endtask

    task automatic test_load();
        run_cmd(0, 1'b1, 3'd0, 8'hA5, 1'b0, 0, 1'b0);
        tests++;
        if (get_cnt(0) !== 16'd1) begin
            fails++; $display("FAIL load_count: got %0d want 1", get_cnt(0));
        end
    endtask

    task automatic test_carry_chain();
        run_cmd(0, 1'b1, 3'd0, 8'hF0, 1'b0, 1, 1'b0);
        run_cmd(0, 1'b0, 3'd0, 8'h20, 1'b0, 0, 1'b0);
        tests++;
        if (acc[0] !== 8'h10 || carry[0] !== 1'b1) begin
            fails++; $display("FAIL chain_add1: acc=%h c=%b want 10 1", acc[0], carry[0]);
        end
        run_cmd(0, 1'b0, 3'd0, 8'h00, 1'b1, 0, 1'b0);
        tests++;
        if (acc[0] !== 8'h11 || carry[0] !== 1'b0) begin
            fails++; $display("FAIL chain_add2: acc=%h c=%b want 11 0", acc[0], carry[0]);
        end
    endtask

    task automatic test_settle3();
        run_cmd(1, 1'b1, 3'd0, 8'hC3, 1'b0, 0, 1'b0);
        run_cmd(1, 1'b0, 3'd0, 8'h7D, 1'b0, 2, 1'b0);
        run_cmd(1, 1'b0, 3'd1, 8'h11, 1'b1, 0, 1'b0);
        run_cmd(1, 1'b0, 3'd4, 8'h5A, 1'b1, 1, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [15:0] c0;
        run_cmd(1, 1'b1, 3'd0, 8'h3C, 1'b0, 0, 1'b0);
        cmd_valid[1] = 1'b1; cmd_load[1] = 1'b0; cmd_op[1] = 3'd0;
        cmd_data[1] = 8'h01; cmd_use_carry[1] = 1'b0; res_ready[1] = 1'b0;
        @(posedge clk); #1;
        repeat (3) begin @(posedge clk); #1; end
        c0 = get_cnt(1);
        cmd_load[1] = 1'b1; cmd_data[1] = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            tests++;
            if (res_valid[1] !== 1'b1 || cmd_ready[1] !== 1'b0 ||
                acc[1] !== 8'h3D || get_cnt(1) !== c0) begin
                fails++;
                $display("FAIL backpressure[%0d]: vld=%b rdy=%b acc=%h cnt=%0d want 1 0 3d %0d",
                         i, res_valid[1], cmd_ready[1], acc[1], get_cnt(1), c0);
            end
        end
        m_acc[1] = 8'h3D; m_carry[1] = 1'b0;
        cmd_valid[1] = 1'b0; res_ready[1] = 1'b1;
        @(posedge clk); #1;
        res_ready[1] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        m_cnt[1]++;
        tests++;
        if (get_cnt(1) !== 16'(c0 + 16'd1) || res_valid[1] !== 1'b0 || acc[1] !== 8'h3D) begin
            fails++;
            $display("FAIL bp_release: cnt=%0d vld=%b acc=%h want %0d 0 3d",
                     get_cnt(1), res_valid[1], acc[1], c0 + 16'd1);
        end
    endtask

    task automatic test_early_ready();
        logic [15:0] c0;
        c0 = get_cnt(0);
        res_ready[0] = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        res_ready[0] = 1'b0;
        tests++;
        if (get_cnt(0) !== c0 || res_valid[0] !== 1'b0 || cmd_ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL early_ready: cnt=%0d vld=%b rdy=%b want %0d 0 1",
                     get_cnt(0), res_valid[0], cmd_ready[0], c0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run_cmd(0, i[0], 3'(i), 8'($urandom), 1'b1, 0, 1'b1);
            run_cmd(1, i[1], 3'(i), 8'($urandom), 1'b1, 0, 1'b1);
        end
    endtask

    task automatic test_reset_mid_exec();
        run_cmd(1, 1'b1, 3'd0, 8'h77, 1'b0, 0, 1'b0);
        cmd_valid[1] = 1'b1; cmd_load[1] = 1'b0; cmd_op[1] = 3'd0;
        cmd_data[1] = 8'h99; cmd_use_carry[1] = 1'b0;
        @(posedge clk); #1;
        cmd_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst_n[1] = 1'b0;
        model_reset(1);
        #1;
        tests++;
        if (res_valid[1] !== 1'b0 || acc[1] !== 8'h00 || carry[1] !== 1'b0 ||
            get_cnt(1) !== 16'd0 || cmd_ready[1] !== 1'b1 || alu_b[1] !== 8'h00) begin
            fails++;
            $display("FAIL async_reset: vld=%b acc=%h c=%b cnt=%0d rdy=%b b=%h want 0 00 0 0 1 00",
                     res_valid[1], acc[1], carry[1], get_cnt(1), cmd_ready[1], alu_b[1]);
        end
        #1;
        rst_n[1] = 1'b1;
        run_cmd(1, 1'b0, 3'd0, 8'h05, 1'b1, 0, 1'b0);
        tests++;
        if (acc[1] !== 8'h05 || get_cnt(1) !== 16'd1) begin
            fails++; $display("FAIL post_reset: acc=%h cnt=%0d want 05 1", acc[1], get_cnt(1));
        end
    endtask

    task automatic test_random();
        int d;
        for (int i = 0; i < 40; i++) begin
            d = i % 2;
            run_cmd(d, ($urandom_range(3) == 0), 3'($urandom), 8'($urandom),
                    1'($urandom), $urandom_range(3), 1'($urandom));
        end
    endtask

    task automatic test_wrap();
        do_reset(0);
        for (int i = 0; i < 17; i++)
            run_cmd(0, 1'b1, 3'd0, 8'(i * 13), 1'b0, 0, 1'b1);
        tests++;
        if (cnt0 !== 4'd1) begin
            fails++; $display("FAIL count_wrap: got %0d want 1", cnt0);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; cmd_valid[d] = 1'b0; cmd_op[d] = 3'd0; cmd_data[d] = 8'h00;
            cmd_load[d] = 1'b0; cmd_use_carry[d] = 1'b0; res_ready[d] = 1'b0;
            model_reset(d);
        end
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(posedge clk); #1;
        test_load();
        test_carry_chain();
        test_settle3();
        test_backpressure();
        test_early_ready();
        test_back_to_back();
        test_random();
        test_reset_mid_exec();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
